// File: rtl/led_mode_ctrl.sv
// Button-driven LED mode controller: OFF -> SOLID -> SLOW -> FAST -> ALT -> OFF.
// Optional key debounce is built in when LED_KEY_DEBOUNCE_EN is defined.
module led_mode_ctrl #(
  parameter int unsigned SLOW_PERIOD     = 12_000_000,
  parameter int unsigned FAST_PERIOD     = 3_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 240_000
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       key_in,
  output logic       led1,
  output logic       led2,
  output logic [2:0] mode,
  output logic       mode_chg
);

  localparam int unsigned CW = $clog2(SLOW_PERIOD);

  localparam logic [CW-1:0] SLOW_LAST = CW'(SLOW_PERIOD - 1);
  localparam logic [CW-1:0] SLOW_HALF = CW'(SLOW_PERIOD / 2);
  localparam logic [CW-1:0] FAST_LAST = CW'(FAST_PERIOD - 1);
  localparam logic [CW-1:0] FAST_HALF = CW'(FAST_PERIOD / 2);

  if (SLOW_PERIOD < 4 || (SLOW_PERIOD % 2) != 0 ||
      FAST_PERIOD < 4 || (FAST_PERIOD % 2) != 0 ||
      FAST_PERIOD >= SLOW_PERIOD || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("led_mode_ctrl: illegal period or debounce parameters");
  end

  typedef enum logic [2:0] {
    M_OFF   = 3'd0,
    M_SOLID = 3'd1,
    M_SLOW  = 3'd2,
    M_FAST  = 3'd3,
    M_ALT   = 3'd4
  } mode_e;

  logic       sync1_q;
  logic       sync2_q;
  logic [1:0] vld_q;
  logic       armed_q;
  logic       prev_q;
  logic       key_acc;
  logic       press;

  // Press detection is armed only after a genuinely sampled released key, so a
  // key held through reset cannot produce a press on the way out of reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      vld_q   <= '0;
      armed_q <= 1'b0;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
      vld_q   <= {vld_q[0], 1'b1};
      if (vld_q[1] && sync2_q) begin
        armed_q <= 1'b1;
      end
      prev_q  <= key_acc;
    end
  end

`ifdef LED_KEY_DEBOUNCE_EN
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          acc_q;
  logic [DW-1:0] db_cnt_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      acc_q    <= 1'b1;
      db_cnt_q <= '0;
    end else if (sync2_q == acc_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DB_LAST) begin
      acc_q    <= sync2_q;
      db_cnt_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_q + DW'(1);
    end
  end

  assign key_acc = acc_q;
`else
  assign key_acc = sync2_q;
`endif

  assign press = armed_q & prev_q & ~key_acc;

  mode_e         mode_q;
  mode_e         mode_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] last;
  logic [CW-1:0] half;
  logic          phase;
  logic          blinking;
  logic          led1_q;
  logic          led1_d;
  logic          led2_q;
  logic          led2_d;
  logic          chg_q;

  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      M_OFF:   if (press) mode_d = M_SOLID;
      M_SOLID: if (press) mode_d = M_SLOW;
      M_SLOW:  if (press) mode_d = M_FAST;
      M_FAST:  if (press) mode_d = M_ALT;
      M_ALT:   if (press) mode_d = M_OFF;
      default: mode_d = M_OFF;
    endcase
  end

  always_comb begin
    last = SLOW_LAST;
    half = SLOW_HALF;
    if (mode_q == M_FAST) begin
      last = FAST_LAST;
      half = FAST_HALF;
    end
  end

  assign blinking = (mode_q == M_SLOW) || (mode_q == M_FAST) || (mode_q == M_ALT);
  assign phase    = (cnt_q >= half);

  // A mode change always restarts the count, even when it coincides with a wrap.
  always_comb begin
    cnt_d = '0;
    if (blinking && (mode_d == mode_q) && (cnt_q != last)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_comb begin
    led1_d = 1'b0;
    led2_d = 1'b0;
    case (mode_q)
      M_SOLID: begin
        led1_d = 1'b1;
        led2_d = 1'b1;
      end
      M_SLOW, M_FAST: begin
        led1_d = phase;
        led2_d = phase;
      end
      M_ALT: begin
        led1_d = phase;
        led2_d = ~phase;
      end
      default: begin
        led1_d = 1'b0;
        led2_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mode_q <= M_OFF;
      cnt_q  <= '0;
      led1_q <= 1'b0;
      led2_q <= 1'b0;
      chg_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      led1_q <= led1_d;
      led2_q <= led2_d;
      chg_q  <= (mode_d != mode_q);
    end
  end

  assign mode     = mode_q;
  assign mode_chg = chg_q;
  assign led1     = led1_q;
  assign led2     = led2_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed self-checking bench for led_mode_ctrl (SLOW=8, FAST=4, DEBOUNCE=4);
// expected latencies follow the LED_KEY_DEBOUNCE_EN build setting.
module tb_led_mode_ctrl;

  localparam int SP = 8;
  localparam int FP = 4;
  localparam int DB = 4;
`ifdef LED_KEY_DEBOUNCE_EN
  localparam int LAT        = DB + 3;
  localparam int BOUNCE_EXP = 0;
`else
  localparam int LAT        = 3;
  localparam int BOUNCE_EXP = 2;
`endif

  logic       clk_in;
  logic       rst_n_in;
  logic       key_in;
  logic       led1;
  logic       led2;
  logic [2:0] mode;
  logic       mode_chg;

  int n_chk;
  int n_err;

  led_mode_ctrl #(
    .SLOW_PERIOD    (SP),
    .FAST_PERIOD    (FP),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .key_in  (key_in),
    .led1    (led1),
    .led2    (led2),
    .mode    (mode),
    .mode_chg(mode_chg)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Press and keep holding; returns right after the edge where mode should change.
  task automatic press_to(input logic [2:0] m);
    logic [2:0] prev_m;
    prev_m = (m == 3'd0) ? 3'd4 : m - 3'd1;
    key_in = 1'b0;
    repeat (LAT - 1) tick();
    chk("mode_before_edge", {29'd0, mode}, {29'd0, prev_m});
    tick();
    chk("mode_after_press", {29'd0, mode}, {29'd0, m});
    chk("chg_pulse", {31'd0, mode_chg}, 32'd1);
  endtask

  task automatic release_key(input logic [2:0] m);
    key_in = 1'b1;
    repeat (LAT + 2) tick();
    chk("mode_after_release", {29'd0, mode}, {29'd0, m});
  endtask

  initial begin
    logic exp_ph;
    n_chk    = 0;
    n_err    = 0;
    rst_n_in = 1'b0;
    key_in   = 1'b1;

    // Reset and idle
    repeat (3) tick();
    chk("in_reset", {26'd0, mode, mode_chg, led1, led2}, 32'd0);
    rst_n_in = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("idle", {26'd0, mode, mode_chg, led1, led2}, 32'd0);
    end

    // One clean press held 20 cycles
    key_in = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("held_press",
          {26'd0, mode, mode_chg, led1, led2},
          {26'd0, (k >= LAT) ? 3'd1 : 3'd0, (k == LAT),
           (k >= LAT + 1), (k >= LAT + 1)});
    end
    release_key(3'd1);

    // SLOW blink: low first, 4 of every 8 cycles high
    press_to(3'd2);
    for (int j = 1; j <= 2 * SP; j++) begin
      tick();
      exp_ph = (((j - 1) % SP) >= SP / 2);
      chk("slow_led1", {31'd0, led1}, {31'd0, exp_ph});
      chk("slow_led2", {31'd0, led2}, {31'd0, exp_ph});
      if (j == 1) chk("slow_chg_single", {31'd0, mode_chg}, 32'd0);
    end
    release_key(3'd2);

    // FAST blink
    press_to(3'd3);
    for (int j = 1; j <= 2 * FP; j++) begin
      tick();
      exp_ph = (((j - 1) % FP) >= FP / 2);
      chk("fast_led1", {31'd0, led1}, {31'd0, exp_ph});
      chk("fast_led2", {31'd0, led2}, {31'd0, exp_ph});
    end
    release_key(3'd3);

    // ALT: led2 is the complement of led1
    press_to(3'd4);
    for (int j = 1; j <= 2 * SP; j++) begin
      tick();
      exp_ph = (((j - 1) % SP) >= SP / 2);
      chk("alt_led1", {31'd0, led1}, {31'd0, exp_ph});
      chk("alt_led2", {31'd0, led2}, {31'd0, ~exp_ph});
    end
    release_key(3'd4);

    // Back to OFF
    press_to(3'd0);
    tick();
    chk("off_leds", {29'd0, mode_chg, led1, led2}, 32'd0);
    release_key(3'd0);

    // Bounce: 2-cycle toggling starting high, 7 low pulses in 30 cycles
    for (int s = 0; s < 15; s++) begin
      key_in = (s % 2 == 1) ? 1'b0 : 1'b1;
      repeat (2) tick();
    end
    key_in = 1'b1;
    repeat (LAT + 2) tick();
    chk("bounce_mode", {29'd0, mode}, BOUNCE_EXP);

    for (int c = BOUNCE_EXP; c < 2; c++) begin
      press_to(3'(c + 1));
      release_key(3'(c + 1));
    end

    // Reset pulse in FAST while the key is still held
    press_to(3'd3);
    repeat (3) tick();
    rst_n_in = 1'b0;
    #1;
    chk("async_reset", {26'd0, mode, mode_chg, led1, led2}, 32'd0);
    tick();
    rst_n_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("held_after_reset", {26'd0, mode, mode_chg, led1, led2}, 32'd0);
    end
    release_key(3'd0);
    press_to(3'd1);
    tick();
    chk("solid_after_repress", {30'd0, led1, led2}, 32'd3);
    release_key(3'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
